// File: rtl/digit_scan_ctrl_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
package digit_scan_ctrl_pkg;

    localparam int unsigned DEFAULT_PRESCALE = 16;
    localparam int unsigned DEFAULT_DEAD     = 2;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned NIB_W            = 4;
    localparam int unsigned SEL_W            = 2;
    localparam int unsigned CNT_W            = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Digit k lives in bits [4k+3:4k].
    function automatic logic [NIB_W-1:0] pick_nibble(input logic [DATA_W-1:0] d,
                                                     input logic [SEL_W-1:0]  s);
        return d[{s, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/data bundle between the display scanner and its host/decoder side.
interface digit_scan_ctrl_if;
    import digit_scan_ctrl_pkg::*;

    logic                 run;
    logic                 load;
    logic [DATA_W-1:0]    data_in;
    logic [SEL_W-1:0]     sel;
    logic                 e;
    logic [NIB_W-1:0]     nibble;
    logic                 frame_done;

    modport master (
        output run, load, data_in,
        input  sel, e, nibble, frame_done
    );

    modport slave (
        input  run, load, data_in,
        output sel, e, nibble, frame_done
    );

endinterface

// File: rtl/digit_scan_ctrl_timer.sv
// Free-running interval counter: counts 0..load_val, flags terminal count, then restarts.
module scan_timer
    import digit_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt;

    assign tc_c = (cnt == load_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || tc_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scan controller: times digit on/blank windows and
// swaps in newly loaded data only at frame boundaries.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned DEAD     = DEFAULT_DEAD
) (
    input  logic              clk,
    input  logic              reset,
    digit_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD == 0) ? 0 : DEAD - 1);
    localparam logic             HAS_DEAD  = (DEAD != 0);

    state_t            state;
    logic [SEL_W-1:0]  sel_r;
    logic              e_r;
    logic [NIB_W-1:0]  nibble_r;
    logic              frame_done_r;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;
    logic              pending;

    logic              tc;
    logic              timer_clr;
    logic [CNT_W-1:0]  load_val;
    logic              start;
    logic              advance;
    logic              to_dead;
    logic              boundary;
    logic [SEL_W-1:0]  sel_nxt;
    logic [DATA_W-1:0] active_nxt;

    assign load_val  = (state == ST_DEAD) ? DEAD_LAST : ON_LAST;
    assign timer_clr = !bus.run || (state == ST_IDLE);

    scan_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr),
        .load_val (load_val),
        .tc_c     (tc)
    );

    assign start    = bus.run && (state == ST_IDLE);
    assign advance  = bus.run && tc &&
                      (((state == ST_ON) && !HAS_DEAD) || (state == ST_DEAD));
    assign to_dead  = bus.run && tc && (state == ST_ON) && HAS_DEAD;
    assign boundary = start || (advance && (sel_r == 2'd3));

    assign sel_nxt    = (!bus.run || start) ? 2'd0 :
                        advance             ? sel_r + 2'd1 : sel_r;
    // A load landing on the boundary edge bypasses the shadow.
    assign active_nxt = boundary ? (bus.load ? bus.data_in : shadow) : active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel_r        <= '0;
            e_r          <= 1'b0;
            nibble_r     <= '0;
            frame_done_r <= 1'b0;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
        end else begin
            sel_r        <= sel_nxt;
            active       <= active_nxt;
            nibble_r     <= pick_nibble(active_nxt, sel_nxt);
            frame_done_r <= bus.run && tc && (state == ST_ON) && (sel_r == 2'd3);

            if (bus.load) shadow <= bus.data_in;
            if (boundary)      pending <= 1'b0;
            else if (bus.load) pending <= 1'b1;

            if (!bus.run) begin
                state <= ST_IDLE;
                e_r   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ON;
                        e_r   <= 1'b1;
                    end
                    ST_ON: begin
                        if (to_dead) begin
                            state <= ST_DEAD;
                            e_r   <= 1'b0;
                        end
                    end
                    ST_DEAD: begin
                        if (advance) begin
                            state <= ST_ON;
                            e_r   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        e_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sel        = sel_r;
    assign bus.e          = e_r;
    assign bus.nibble     = nibble_r;
    assign bus.frame_done = frame_done_r;

endmodule
